// File: rtl/bird_pkg.sv
// Shared constants for the bird state machine and its datapath:
// state codes, screen geometry, colours and saturating arithmetic.
package bird_pkg;

  localparam logic [3:0] ST_HOLD    = 4'd0;
  localparam logic [3:0] ST_LEFT    = 4'd1;
  localparam logic [3:0] ST_RIGHT   = 4'd2;
  localparam logic [3:0] ST_UP      = 4'd3;
  localparam logic [3:0] ST_DOWN    = 4'd4;
  localparam logic [3:0] ST_CLEAR   = 4'd5;
  localparam logic [3:0] ST_DRAW    = 4'd6;
  localparam logic [3:0] ST_SHOT    = 4'd7;
  localparam logic [3:0] ST_ESCAPE  = 4'd8;
  localparam logic [3:0] ST_PREHOLD = 4'd9;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPR      = 8;
  localparam int SPR_LOG2 = $clog2(SPR);
  localparam int PIX_W    = 2 * SPR_LOG2;

  localparam logic [7:0] X_MAX   = 8'(SCREEN_W - SPR);
  localparam logic [6:0] Y_MAX   = 7'(SCREEN_H - SPR);
  localparam logic [7:0] START_X = 8'd76;
  localparam logic [6:0] START_Y = 7'd100;
  localparam logic [7:0] STEP    = 8'd1;
  localparam logic [7:0] FALL    = 8'd2;

  localparam logic [2:0] BIRD_C = 3'b110;
  localparam logic [2:0] SHOT_C = 3'b100;
  localparam logic [2:0] BG_C   = 3'b011;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_CLR,
    PH_DRW,
    PH_WAIT,
    PH_FALL_ERS,
    PH_FALL_DRW,
    PH_WAIT_FALL,
    PH_FALL_END
  } phase_t;

  // v + d clamped to lim; 9-bit sum so nothing wraps before the compare
  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [7:0] d,
                                         input logic [7:0] lim);
    logic [8:0] s;
    s = {1'b0, v} + {1'b0, d};
    return (s > {1'b0, lim}) ? lim : s[7:0];
  endfunction

  // v - d clamped to 0
  function automatic logic [7:0] sat_sub(input logic [7:0] v, input logic [7:0] d);
    return (v < d) ? 8'd0 : (v - d);
  endfunction

endpackage

// File: rtl/sprite_sweep.sv
// Walks an SPR x SPR square one pixel per clock, row-major, producing
// registered VGA plot outputs. A start restarts from pixel 0 even mid-sweep.
module sprite_sweep
  import bird_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);

  logic             active_q;
  logic [PIX_W-1:0] pix_q;
  logic [7:0]       base_x_q;
  logic [6:0]       base_y_q;
  logic [2:0]       colour_q;
  logic [7:0]       x_q;
  logic [6:0]       y_q;
  logic [2:0]       col_q;
  logic             plot_q;
  logic             done_q;

  // Pixel 0 is emitted on the start edge so the first plot lands one cycle
  // after the request; done is high alongside the last plotted pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      pix_q    <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      colour_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      if (start) begin
        base_x_q <= base_x;
        base_y_q <= base_y;
        colour_q <= colour;
        x_q      <= base_x;
        y_q      <= base_y;
        col_q    <= colour;
        plot_q   <= 1'b1;
        pix_q    <= PIX_W'(1);
        active_q <= 1'b1;
      end else if (abort) begin
        active_q <= 1'b0;
        pix_q    <= '0;
      end else if (active_q) begin
        x_q    <= base_x_q + {{(8 - SPR_LOG2){1'b0}}, pix_q[SPR_LOG2-1:0]};
        y_q    <= base_y_q + {{(7 - SPR_LOG2){1'b0}}, pix_q[PIX_W-1:SPR_LOG2]};
        col_q  <= colour_q;
        plot_q <= 1'b1;
        pix_q  <= pix_q + PIX_W'(1);
        if (pix_q == '1) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign vga_plot   = plot_q;
  assign done       = done_q;

endmodule

// File: rtl/bird_datapath.sv
// Bird position keeper and sprite draw engine sitting behind the bird FSM.
//
// phase         | meaning
// PH_IDLE       | nothing in flight, waiting for a state change
// PH_CLR        | erasing sprite at drawn position
// PH_DRW        | painting sprite at bird position
// PH_WAIT       | sweep finished, waiting for a tick before enable_draw
// PH_FALL_ERS   | fall step: erasing at current position
// PH_FALL_DRW   | fall step: painting at the moved position
// PH_WAIT_FALL  | fall step painted, waiting for a tick
// PH_FALL_END   | last erase at the floor/ceiling, no repaint
module bird_datapath
  import bird_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] state,
  input  logic       tick,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       enable_draw,
  output logic       flying,
  output logic [7:0] bird_x,
  output logic [6:0] bird_y
);

  logic [3:0] prev_q;
  phase_t     phase_q;
  logic [7:0] bird_x_q;
  logic [6:0] bird_y_q;
  logic [7:0] drawn_x_q;
  logic [6:0] drawn_y_q;
  logic       tick_pend_q;
  logic       enable_q;
  logic       flying_q;

  logic [3:0] st;
  logic       entry;
  logic       tick_now;
  logic       is_shot;
  logic       fall_end;
  logic [6:0] fall_y_d;
  logic [2:0] fall_col;

  logic       sw_start;
  logic       sw_abort;
  logic [7:0] sw_bx;
  logic [6:0] sw_by;
  logic [2:0] sw_col;
  logic       sw_done;

  // Decode the incoming state (unknown codes fold to HOLD) and the fall step.
  always_comb begin
    st       = (state > ST_PREHOLD) ? ST_HOLD : state;
    entry    = (st != prev_q);
    tick_now = tick_pend_q | tick;
    is_shot  = (st == ST_SHOT);
    fall_y_d = is_shot ? 7'(sat_add({1'b0, bird_y_q}, FALL, {1'b0, Y_MAX}))
                       : 7'(sat_sub({1'b0, bird_y_q}, FALL));
    fall_end = is_shot ? (bird_y_q == Y_MAX) : (bird_y_q == 7'd0);
    fall_col = is_shot ? SHOT_C : BIRD_C;
  end

  // Sweep launch: combinational so each sweep's first pixel follows its
  // trigger by one cycle and erase/draw run back to back.
  always_comb begin
    sw_start = 1'b0;
    sw_abort = 1'b0;
    sw_bx    = drawn_x_q;
    sw_by    = drawn_y_q;
    sw_col   = BG_C;
    if (entry) begin
      sw_abort = 1'b1;
      case (st)
        ST_CLEAR, ST_SHOT, ST_ESCAPE: sw_start = 1'b1;
        ST_DRAW: begin
          sw_start = 1'b1;
          sw_bx    = bird_x_q;
          sw_by    = bird_y_q;
          sw_col   = BIRD_C;
        end
        default: ;
      endcase
    end else begin
      case (phase_q)
        PH_FALL_ERS: if (sw_done) begin
          sw_start = 1'b1;
          sw_bx    = bird_x_q;
          sw_by    = fall_y_d;
          sw_col   = fall_col;
        end
        // drawn is only updated on this edge, so erase from bird directly
        PH_FALL_DRW, PH_WAIT_FALL: begin
          if ((sw_done || phase_q == PH_WAIT_FALL) && tick_now) begin
            sw_start = 1'b1;
            sw_bx    = bird_x_q;
            sw_by    = bird_y_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Main sequencer: position updates, phase tracking and handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= ST_PREHOLD;
      phase_q     <= PH_IDLE;
      bird_x_q    <= START_X;
      bird_y_q    <= START_Y;
      drawn_x_q   <= START_X;
      drawn_y_q   <= START_Y;
      tick_pend_q <= 1'b0;
      enable_q    <= 1'b0;
      flying_q    <= 1'b0;
    end else begin
      prev_q   <= st;
      enable_q <= 1'b0;
      if (tick) tick_pend_q <= 1'b1;
      if (entry) begin
        // a tick left over from the previous state must not finish this one
        tick_pend_q <= tick;
        phase_q     <= PH_IDLE;
        case (st)
          ST_LEFT:  bird_x_q <= sat_sub(bird_x_q, STEP);
          ST_RIGHT: bird_x_q <= sat_add(bird_x_q, STEP, X_MAX);
          ST_UP:    bird_y_q <= 7'(sat_sub({1'b0, bird_y_q}, STEP));
          ST_DOWN:  bird_y_q <= 7'(sat_add({1'b0, bird_y_q}, STEP, {1'b0, Y_MAX}));
          ST_CLEAR: phase_q <= PH_CLR;
          ST_DRAW:  phase_q <= PH_DRW;
          ST_SHOT, ST_ESCAPE: begin
            flying_q <= 1'b1;
            phase_q  <= fall_end ? PH_FALL_END : PH_FALL_ERS;
          end
          ST_PREHOLD: begin
            bird_x_q  <= START_X;
            bird_y_q  <= START_Y;
            drawn_x_q <= START_X;
            drawn_y_q <= START_Y;
            flying_q  <= 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (phase_q)
          PH_CLR, PH_DRW, PH_FALL_END: begin
            if (sw_done) begin
              if (phase_q == PH_DRW) begin
                drawn_x_q <= bird_x_q;
                drawn_y_q <= bird_y_q;
              end
              if (phase_q == PH_FALL_END) flying_q <= 1'b0;
              if (tick_now) begin
                enable_q    <= 1'b1;
                tick_pend_q <= 1'b0;
                phase_q     <= PH_IDLE;
              end else begin
                phase_q <= PH_WAIT;
              end
            end
          end
          PH_WAIT: begin
            if (tick_now) begin
              enable_q    <= 1'b1;
              tick_pend_q <= 1'b0;
              phase_q     <= PH_IDLE;
            end
          end
          PH_FALL_ERS: begin
            if (sw_done) begin
              bird_y_q <= fall_y_d;
              phase_q  <= PH_FALL_DRW;
            end
          end
          PH_FALL_DRW, PH_WAIT_FALL: begin
            if (sw_done && phase_q == PH_FALL_DRW) begin
              drawn_x_q <= bird_x_q;
              drawn_y_q <= bird_y_q;
            end
            if ((sw_done || phase_q == PH_WAIT_FALL) && tick_now) begin
              enable_q    <= 1'b1;
              tick_pend_q <= 1'b0;
              phase_q     <= fall_end ? PH_FALL_END : PH_FALL_ERS;
            end else if (sw_done) begin
              phase_q <= PH_WAIT_FALL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sprite_sweep u_sweep (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (sw_start),
    .abort      (sw_abort),
    .base_x     (sw_bx),
    .base_y     (sw_by),
    .colour     (sw_col),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (sw_done)
  );

  assign enable_draw = enable_q;
  assign flying      = flying_q;
  assign bird_x      = bird_x_q;
  assign bird_y      = bird_y_q;

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath: movement, clear/draw sweeps, tick
// handshake, saturation, falling/escaping and reset behaviour.
module tb_bird_datapath;

  localparam logic [3:0] S_HOLD    = 4'd0;
  localparam logic [3:0] S_RIGHT   = 4'd2;
  localparam logic [3:0] S_UP      = 4'd3;
  localparam logic [3:0] S_DOWN    = 4'd4;
  localparam logic [3:0] S_CLEAR   = 4'd5;
  localparam logic [3:0] S_DRAW    = 4'd6;
  localparam logic [3:0] S_SHOT    = 4'd7;
  localparam logic [3:0] S_ESCAPE  = 4'd8;
  localparam logic [3:0] S_PREHOLD = 4'd9;
  localparam logic [2:0] C_BG   = 3'b011;
  localparam logic [2:0] C_BIRD = 3'b110;
  localparam logic [2:0] C_SHOT = 3'b100;

  logic       clk;
  logic       reset_n;
  logic [3:0] state;
  logic       tick;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       enable_draw;
  logic       flying;
  logic [7:0] bird_x;
  logic [6:0] bird_y;

  int checks;
  int failures;
  int cyc, n_plot, n_badcol, n_shotc, n_shot_low, n_en, last_plot, en_cyc;
  int min_x, max_x, min_y, max_y;
  logic [2:0] exp_col;
  logic [6:0] en_y [8];
  logic       en_fly [8];

  bird_datapath dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .state       (state),
    .tick        (tick),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .enable_draw (enable_draw),
    .flying      (flying),
    .bird_x      (bird_x),
    .bird_y      (bird_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; n_plot = 0; n_badcol = 0; n_shotc = 0; n_shot_low = 0;
    n_en = 0; last_plot = -1; en_cyc = -1;
    min_x = 1000; max_x = -1; min_y = 1000; max_y = -1;
  endtask

  // one clock; outputs sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (vga_plot === 1'b1) begin
      n_plot++;
      last_plot = cyc;
      if (int'(vga_x) < min_x) min_x = int'(vga_x);
      if (int'(vga_x) > max_x) max_x = int'(vga_x);
      if (int'(vga_y) < min_y) min_y = int'(vga_y);
      if (int'(vga_y) > max_y) max_y = int'(vga_y);
      if (vga_colour !== exp_col) n_badcol++;
      if (vga_colour === C_SHOT) begin
        n_shotc++;
        if (vga_y >= 7'd120) n_shot_low++;
      end
    end
    if (enable_draw === 1'b1) begin
      if (n_en < 8) begin
        en_y[n_en]   = bird_y;
        en_fly[n_en] = flying;
      end
      n_en++;
      en_cyc = cyc;
    end
  endtask

  task automatic move(input logic [3:0] dir, input int n);
    for (int i = 0; i < n; i++) begin
      state = S_HOLD;
      step();
      state = dir;
      step();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    state = S_HOLD; tick = 1'b0; reset_n = 1'b0; exp_col = C_BG;
    clr_stats();
    step(); step();
    chk("rst_bird_x", bird_x, 76);
    chk("rst_bird_y", bird_y, 100);
    chk("rst_plot", vga_plot, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_enable", enable_draw, 0);
    chk("rst_flying", flying, 0);
    reset_n = 1'b1;
    step();

    // HOLD -> RIGHT -> DOWN -> CLEAR
    state = S_RIGHT; step();
    chk("right_x", bird_x, 77);
    state = S_DOWN; step();
    chk("down_y", bird_y, 101);
    state = S_CLEAR; exp_col = C_BG; clr_stats();
    step();
    chk("clr_first_plot", vga_plot, 1);
    chk("clr_first_x", vga_x, 76);
    chk("clr_first_y", vga_y, 100);
    chk("clr_first_col", vga_colour, C_BG);
    for (int i = 0; i < 69; i++) begin
      tick = (i == 9);
      step();
    end
    tick = 1'b0;
    chk("clr_plots", n_plot, 64);
    chk("clr_min_x", min_x, 76);
    chk("clr_max_x", max_x, 83);
    chk("clr_min_y", min_y, 100);
    chk("clr_max_y", max_y, 107);
    chk("clr_badcol", n_badcol, 0);
    chk("clr_en_cnt", n_en, 1);
    chk("clr_en_cyc", en_cyc, 65);

    // DRAW at the moved position
    state = S_DRAW; exp_col = C_BIRD; clr_stats();
    for (int i = 0; i < 70; i++) begin
      tick = (i == 29);
      step();
    end
    tick = 1'b0;
    chk("drw_plots", n_plot, 64);
    chk("drw_min_x", min_x, 77);
    chk("drw_max_x", max_x, 84);
    chk("drw_min_y", min_y, 101);
    chk("drw_max_y", max_y, 108);
    chk("drw_badcol", n_badcol, 0);
    chk("drw_en_cnt", n_en, 1);
    chk("drw_bird_x", bird_x, 77);
    chk("drw_bird_y", bird_y, 101);

    // tick held off 10 cycles past the end of a CLEAR sweep
    state = S_CLEAR; exp_col = C_BG; clr_stats();
    for (int i = 0; i < 74; i++) step();
    chk("late_plots", n_plot, 64);
    chk("late_no_en", n_en, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("late_en_now", enable_draw, 1);
    chk("late_en_cyc", en_cyc, 75);
    step();
    chk("late_en_drop", enable_draw, 0);
    chk("late_en_cnt", n_en, 1);

    // two ticks inside one sweep give a single pulse
    state = S_DRAW; exp_col = C_BIRD; clr_stats();
    for (int i = 0; i < 80; i++) begin
      tick = (i == 5 || i == 20);
      step();
    end
    tick = 1'b0;
    chk("dbl_en_cnt", n_en, 1);
    chk("dbl_plots", n_plot, 64);

    // right-edge and top-edge saturation, undefined code as HOLD
    move(S_RIGHT, 75);
    chk("sat_x_152", bird_x, 152);
    move(S_RIGHT, 1);
    chk("sat_x_hold", bird_x, 152);
    move(S_UP, 101);
    chk("sat_y_0", bird_y, 0);
    move(S_UP, 1);
    chk("sat_y_hold", bird_y, 0);
    clr_stats();
    state = S_HOLD; step();
    state = 4'd12; step(); step();
    chk("undef_x", bird_x, 152);
    chk("undef_y", bird_y, 0);
    chk("undef_plots", n_plot, 0);

    // position at y=104 and paint it so drawn matches bird
    move(S_DOWN, 104);
    chk("down_104", bird_y, 104);
    state = S_DRAW; exp_col = C_BIRD; clr_stats();
    tick = 1'b1; step(); tick = 1'b0;
    for (int i = 0; i < 70; i++) step();
    chk("pre_shot_en", n_en, 1);

    // SHOT: erase+draw back to back, then ticked steps down to the floor
    state = S_SHOT; clr_stats();
    step();
    chk("shot_flying", flying, 1);
    for (int i = 0; i < 127; i++) step();
    chk("shot_run_plots", n_plot, 128);
    chk("shot_run_shotc", n_shotc, 64);
    chk("shot_first_y", bird_y, 106);
    for (int i = 0; i < 1000; i++) begin
      tick = ((i % 40) == 39);
      step();
    end
    tick = 1'b0;
    chk("shot_en_cnt", n_en, 5);
    chk("shot_en0_y", en_y[0], 106);
    chk("shot_en1_y", en_y[1], 108);
    chk("shot_en2_y", en_y[2], 110);
    chk("shot_en3_y", en_y[3], 112);
    chk("shot_en4_y", en_y[4], 112);
    chk("shot_en3_fly", en_fly[3], 1);
    chk("shot_en4_fly", en_fly[4], 0);
    chk("shot_shotc", n_shotc, 256);
    chk("shot_below", n_shot_low, 0);
    chk("shot_end_y", bird_y, 112);
    chk("shot_end_fly", flying, 0);

    // ESCAPE from y=4, then PREHOLD
    move(S_UP, 108);
    chk("up_4", bird_y, 4);
    state = S_ESCAPE; clr_stats();
    for (int i = 0; i < 600; i++) begin
      tick = ((i % 40) == 39);
      step();
    end
    tick = 1'b0;
    chk("esc_en_cnt", n_en, 3);
    chk("esc_en0_y", en_y[0], 2);
    chk("esc_en1_y", en_y[1], 0);
    chk("esc_en1_fly", en_fly[1], 1);
    chk("esc_en2_fly", en_fly[2], 0);
    chk("esc_shotc", n_shotc, 0);
    state = S_PREHOLD; clr_stats();
    for (int i = 0; i < 10; i++) step();
    chk("pre_x", bird_x, 76);
    chk("pre_y", bird_y, 100);
    chk("pre_fly", flying, 0);
    chk("pre_plots", n_plot, 0);

    // reset in the middle of a DRAW sweep at pix=20
    state = S_RIGHT; step();
    state = S_DRAW;
    for (int i = 0; i < 21; i++) step();
    chk("mid_plot", vga_plot, 1);
    chk("mid_x", vga_x, 81);
    chk("mid_y", vga_y, 102);
    reset_n = 1'b0;
    #1;
    chk("arst_plot", vga_plot, 0);
    chk("arst_vga_x", vga_x, 0);
    chk("arst_vga_y", vga_y, 0);
    chk("arst_col", vga_colour, 0);
    chk("arst_bird_x", bird_x, 76);
    chk("arst_bird_y", bird_y, 100);
    chk("arst_en", enable_draw, 0);
    state = S_HOLD;
    step();
    reset_n = 1'b1;
    clr_stats();
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_plots", n_plot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
